reflex_round_ctrl: RTL
======================

# reflex_round_ctrl

Round sequencer for the reflex trainer. Places one 40×40 target ball at a pseudo-random on-screen position and runs a per-ball reaction timer. It consumes the registered-free hit indication from the mouse/ball hit detector, scores hits and misses, and ends the game after a fixed number of balls. The block sits between the PS/2 mouse hit logic and the VGA ball renderer/score display.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 40, ball edge length in pixels
- TIMEOUT_MS, 1000, ball lifetime in ms (1..4095)
- GAP_MS, 200, blank time between balls in ms (1..4095)
- ROUNDS, 20, balls per game (1..255)
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  level; starts a game from IDLE or DONE
- TICK_1MS  in  1  one-CLK strobe every millisecond
- HIT  in  1  level from the hit detector (ball hit or skip request)
- BALL_X  out  10  ball top-left X, registered
- BALL_Y  out  10  ball top-left Y, registered
- BALL_VISIBLE  out  1  ball drawn/active
- HITS  out  8  balls hit this game
- MISSES  out  8  balls timed out this game
- LAST_RT_MS  out  12  reaction time of most recent hit, ms
- BEST_RT_MS  out  12  minimum reaction time this game
- ROUND  out  8  balls completed this game
- GAME_OVER  out  1  high in DONE

## Operation
- States: IDLE, GAP, SHOW, DONE (2-bit encoding, registered).
- IDLE: BALL_VISIBLE=0. START=1 → clear HITS, MISSES, ROUND, LAST_RT_MS=0, BEST_RT_MS=12'hFFF, ms counter=0 → GAP.
- GAP: ms counter increments on TICK_1MS. On TICK_1MS with counter==GAP_MS-1 → latch BALL_X/BALL_Y, clear counter → SHOW.
- Position: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It advances every CLK, including IDLE, and is never zero.
  - BALL_X = (lfsr[9:0] × (SCREEN_W−BALL_SIZE)) >> 10.
  - BALL_Y = (lfsr[15:6] × (SCREEN_H−BALL_SIZE)) >> 10.
  - Products are 20 bits wide, so results are always in range and the ball is fully on screen.
- SHOW: BALL_VISIBLE=1. The ms counter increments on TICK_1MS.
  - Hit = HIT rising edge. The edge is detected against a registered HIT_d, which updates every CLK and resets to 0.
  - On a hit: HITS+1, LAST_RT_MS=counter, BEST_RT_MS=min(BEST_RT_MS, counter), ROUND+1 → GAP, or DONE if ROUND+1==ROUNDS.
  - On timeout (TICK_1MS with counter==TIMEOUT_MS-1, no hit): MISSES+1, ROUND+1 → GAP/DONE by the same rule.
- DONE: GAME_OVER=1, BALL_VISIBLE=0. Counters hold. START=1 → same clearing as in IDLE → GAP.
- START is ignored in GAP and SHOW. HIT is ignored outside SHOW, but HIT_d still tracks it.
- HITS, MISSES, and ROUND are 8 bits and cannot overflow because ROUNDS≤255. The ms counter is 12 bits.

## Timing
- Reset (async, any state) values:
  - state=IDLE; all outputs 0 except BEST_RT_MS=12'hFFF.
  - LFSR=16'hACE1; HIT_d=0; ms counter=0.
- All outputs are registered and change on the CLK edge that performs the transition, so BALL_VISIBLE rises on the same edge that latches BALL_X/BALL_Y.
- Hit latency: a HIT rise sampled at edge n is scored at edge n. State, HITS, and BALL_VISIBLE update at that edge, with no extra cycle.
- A HIT already high when SHOW is entered does not score. It must fall and rise again. A held middle button therefore skips at most one ball.
- Hit and timeout on the same edge: the hit wins and counts as a hit with LAST_RT_MS=TIMEOUT_MS-1.
- The reaction time resolution is 1 ms and counts completed ticks. A hit before the first tick reports 0.
- Gap length is exactly GAP_MS ticks. Ball lifetime is exactly TIMEOUT_MS ticks.
- RESET asserted mid-SHOW: the ball disappears immediately (async) and the score is lost.

## Test plan
- Reset, then START pulse with TICK_1MS every 10 CLK and GAP_MS=200 → BALL_VISIBLE rises 200 ticks after START. BALL_X<600, BALL_Y<440, and the values match the LFSR model.
- In SHOW, raise HIT after 37 ticks → HITS=1, LAST_RT_MS=37, BEST_RT_MS=37, ROUND=1, BALL_VISIBLE=0 on the same edge.
- No HIT for 1000 ticks → MISSES=1 on the 1000th tick. A HIT rise coinciding with that tick → HITS=1, MISSES=0, LAST_RT_MS=999.
- Hold HIT high across GAP→SHOW → no score. Release, then raise after 5 more ticks → score with RT = ticks elapsed since SHOW.
- ROUNDS=3 with hit, miss, hit (RT 50, 20) → GAME_OVER=1, HITS=2, MISSES=1, BEST_RT_MS=20. START in DONE clears the scores and enters GAP.
- Assert RESET mid-SHOW → all outputs at reset values immediately. A START pulse during SHOW is ignored.

Source files
------------

// File: rtl/reflex_round_ctrl_if.sv
// Bus between the reflex round sequencer and its neighbours: the hit detector,
// the 1 ms timebase, the ball renderer and the score display.
// The slave side is the sequencer. The master side drives start, tick and hit.
interface reflex_round_ctrl_if;
    // Control inputs to the sequencer
    logic        start;
    logic        tick_1ms;
    logic        hit;

    // Ball placement and visibility
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        ball_visible;

    // Score and game progress
    logic [7:0]  hits;
    logic [7:0]  misses;
    logic [11:0] last_rt_ms;
    logic [11:0] best_rt_ms;
    logic [7:0]  round;
    logic        game_over;

    modport master (
        output start,
        output tick_1ms,
        output hit,
        input  ball_x,
        input  ball_y,
        input  ball_visible,
        input  hits,
        input  misses,
        input  last_rt_ms,
        input  best_rt_ms,
        input  round,
        input  game_over
    );

    modport slave (
        input  start,
        input  tick_1ms,
        input  hit,
        output ball_x,
        output ball_y,
        output ball_visible,
        output hits,
        output misses,
        output last_rt_ms,
        output best_rt_ms,
        output round,
        output game_over
    );
endinterface

// File: rtl/reflex_round_ctrl.sv
// Round sequencer for the reflex trainer. It places one ball per round at an
// LFSR-derived position and times the player's reaction in 1 ms ticks. It
// scores hits and misses and stops after a fixed number of balls.
module reflex_round_ctrl #(
    parameter int unsigned ScreenW   = 640,
    parameter int unsigned ScreenH   = 480,
    parameter int unsigned BallSize  = 40,
    parameter int unsigned TimeoutMs = 1000,
    parameter int unsigned GapMs     = 200,
    parameter int unsigned Rounds    = 20
) (
    input logic               clk,
    input logic               rst,
    reflex_round_ctrl_if.slave bus
);

    // Last counter value of each timed phase; the phase ends on the tick seen there
    localparam logic [11:0] GapLast     = 12'(GapMs - 1);
    localparam logic [11:0] TimeoutLast = 12'(TimeoutMs - 1);
    localparam logic [7:0]  RoundsVal   = 8'(Rounds);

    // Placement ranges keep the whole ball on screen
    localparam logic [9:0]  XRange      = 10'(ScreenW - BallSize);
    localparam logic [9:0]  YRange      = 10'(ScreenH - BallSize);

    localparam logic [15:0] LfsrSeed    = 16'hACE1;
    localparam logic [11:0] BestInit    = 12'hFFF;

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StShow,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        hit_prev_q;
    logic [11:0] ms_cnt_q, ms_cnt_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        visible_q, visible_d;
    logic        over_q, over_d;
    logic [7:0]  hits_q, hits_d;
    logic [7:0]  misses_q, misses_d;
    logic [7:0]  round_q, round_d;
    logic [11:0] last_rt_q, last_rt_d;
    logic [11:0] best_rt_q, best_rt_d;

    logic        hit_rise;
    logic [7:0]  round_inc;
    logic        last_ball;
    logic        ball_end;

    // A held button must be released before it can score again
    assign hit_rise  = bus.hit & ~hit_prev_q;
    assign round_inc = round_q + 8'd1;
    assign last_ball = (round_inc == RoundsVal);

    // Fibonacci LFSR, taps 16,14,13,11, shifting right; never reaches zero from the seed
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // State and score registers; reset clears the ball at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= LfsrSeed;
            hit_prev_q <= 1'b0;
            ms_cnt_q   <= 12'd0;
            ball_x_q   <= 10'd0;
            ball_y_q   <= 10'd0;
            visible_q  <= 1'b0;
            over_q     <= 1'b0;
            hits_q     <= 8'd0;
            misses_q   <= 8'd0;
            round_q    <= 8'd0;
            last_rt_q  <= 12'd0;
            best_rt_q  <= BestInit;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            hit_prev_q <= bus.hit;
            ms_cnt_q   <= ms_cnt_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            visible_q  <= visible_d;
            over_q     <= over_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            round_q    <= round_d;
            last_rt_q  <= last_rt_d;
            best_rt_q  <= best_rt_d;
        end
    end

    // Next-state and next-output logic for the round sequencer
    always_comb begin
        state_d   = state_q;
        ms_cnt_d  = ms_cnt_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        visible_d = visible_q;
        over_d    = over_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        round_d   = round_q;
        last_rt_d = last_rt_q;
        best_rt_d = best_rt_q;
        ball_end  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    hits_d    = 8'd0;
                    misses_d  = 8'd0;
                    round_d   = 8'd0;
                    last_rt_d = 12'd0;
                    best_rt_d = BestInit;
                    ms_cnt_d  = 12'd0;
                    visible_d = 1'b0;
                    over_d    = 1'b0;
                    state_d   = StGap;
                end
            end

            StGap: begin
                if (bus.tick_1ms) begin
                    if (ms_cnt_q == GapLast) begin
                        // Scale the 10-bit random fraction into the on-screen range
                        ball_x_d  = 10'(({10'd0, lfsr_q[9:0]} * {10'd0, XRange}) >> 10);
                        ball_y_d  = 10'(({10'd0, lfsr_q[15:6]} * {10'd0, YRange}) >> 10);
                        ms_cnt_d  = 12'd0;
                        visible_d = 1'b1;
                        state_d   = StShow;
                    end else begin
                        ms_cnt_d = ms_cnt_q + 12'd1;
                    end
                end
            end

            StShow: begin
                // The hit takes priority over a timeout tick on the same edge
                if (hit_rise) begin
                    hits_d    = hits_q + 8'd1;
                    last_rt_d = ms_cnt_q;
                    if (ms_cnt_q < best_rt_q) begin
                        best_rt_d = ms_cnt_q;
                    end
                    ball_end = 1'b1;
                end else if (bus.tick_1ms) begin
                    if (ms_cnt_q == TimeoutLast) begin
                        misses_d = misses_q + 8'd1;
                        ball_end = 1'b1;
                    end else begin
                        ms_cnt_d = ms_cnt_q + 12'd1;
                    end
                end

                if (ball_end) begin
                    round_d   = round_inc;
                    ms_cnt_d  = 12'd0;
                    visible_d = 1'b0;
                    if (last_ball) begin
                        over_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
        endcase
    end

    assign bus.ball_x       = ball_x_q;
    assign bus.ball_y       = ball_y_q;
    assign bus.ball_visible = visible_q;
    assign bus.hits         = hits_q;
    assign bus.misses       = misses_q;
    assign bus.last_rt_ms   = last_rt_q;
    assign bus.best_rt_ms   = best_rt_q;
    assign bus.round        = round_q;
    assign bus.game_over    = over_q;

endmodule
